// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core widths, instruction type and the canonical NOP encoding.
package riscv_pkg;
    localparam int XLEN = 64;
    localparam int ILEN = 32;
    typedef logic [ILEN-1:0] instruction_t;
    localparam instruction_t NOP_INSTR = 32'h00000013;
endpackage

// File: rtl/instruction_memory.sv
// instruction_memory: word-addressed IMEM, combinational read, synchronous preload write, no reset.
module instruction_memory
    import riscv_pkg::*;
#(
    parameter int IMEM_WORDS = 64
) (
    input  logic                          clk,
    input  logic                          we_i,
    input  logic [$clog2(IMEM_WORDS)-1:0] waddr_i,
    input  logic [ILEN-1:0]               wdata_i,
    input  logic [$clog2(IMEM_WORDS)-1:0] raddr_i,
    output logic [ILEN-1:0]               rdata_o
);
    instruction_t mem [IMEM_WORDS];
    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end
    assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/if_stage.sv
// if_stage: PC register, IMEM fetch and IF/ID register with stall and branch flush.
// Optional IF_STAGE_PERF_CNT_EN adds fetch/stall/flush event counters.
module if_stage
    import riscv_pkg::*;
#(
    parameter logic [63:0] PC_RESET   = 64'h0,
    parameter int          IMEM_WORDS = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          stall,
    input  logic                          branch_taken,
    input  logic [63:0]                   branch_target,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_WORDS)-1:0] imem_waddr,
    input  logic [31:0]                   imem_wdata,
    output logic [63:0]                   PC_Out,
    output logic [63:0]                   ifid_pc,
    output logic [31:0]                   ifid_instr,
    output logic                          ifid_valid
`ifdef IF_STAGE_PERF_CNT_EN
    ,
    output logic [31:0]                   fetch_cnt,
    output logic [31:0]                   stall_cnt,
    output logic [31:0]                   flush_cnt
`endif
);
    localparam int AW = $clog2(IMEM_WORDS);

    instruction_t   fetch_word;
    logic [XLEN-1:0] pc_q, pc_d, ifid_pc_q, ifid_pc_d;
    instruction_t   ifid_instr_q, ifid_instr_d;
    logic           ifid_valid_q, ifid_valid_d;

    // Upper PC bits are dropped so fetches wrap modulo the memory depth.
    instruction_memory #(.IMEM_WORDS(IMEM_WORDS)) u_imem (
        .clk     (clk),
        .we_i    (imem_we),
        .waddr_i (imem_waddr),
        .wdata_i (imem_wdata),
        .raddr_i (pc_q[2 +: AW]),
        .rdata_o (fetch_word)
    );

    always_comb begin
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        if (branch_taken) begin
            pc_d         = branch_target & ~XLEN'(3);
            ifid_pc_d    = '0;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
        end else if (!stall) begin
            pc_d         = pc_q + XLEN'(4);
            ifid_pc_d    = pc_q;
            ifid_instr_d = fetch_word;
            ifid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= PC_RESET;
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign PC_Out     = pc_q;
    assign ifid_pc    = ifid_pc_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_valid = ifid_valid_q;

`ifdef IF_STAGE_PERF_CNT_EN
    logic [31:0] fetch_q, stall_q, flush_q;
    always_ff @(posedge clk) begin
        fetch_q <= reset ? '0 : fetch_q + 32'(!branch_taken && !stall);
        stall_q <= reset ? '0 : stall_q + 32'(!branch_taken && stall);
        flush_q <= reset ? '0 : flush_q + 32'(branch_taken);
    end
    assign fetch_cnt = fetch_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`endif
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed table-driven check of fetch, stall, branch flush, wrap, write-vs-fetch and reset.
module tb_if_stage;
    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] NEW5 = 32'h12345678;

    logic        clk, reset, stall, branch_taken, imem_we;
    logic [63:0] branch_target;
    logic [5:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic [63:0] PC_Out, ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    int          checks = 0, failures = 0;
    int          m_fetch = 0, m_stall = 0, m_flush = 0;
`ifdef IF_STAGE_PERF_CNT_EN
    logic [31:0] fetch_cnt, stall_cnt, flush_cnt;
`endif

    if_stage #(.PC_RESET(64'h0), .IMEM_WORDS(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_we       (imem_we),
        .imem_waddr    (imem_waddr),
        .imem_wdata    (imem_wdata),
        .PC_Out        (PC_Out),
        .ifid_pc       (ifid_pc),
        .ifid_instr    (ifid_instr),
        .ifid_valid    (ifid_valid)
`ifdef IF_STAGE_PERF_CNT_EN
        ,
        .fetch_cnt     (fetch_cnt),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst, stl, br;
        logic [63:0] tgt;
        logic        we;
        logic [5:0]  wa;
        logic [31:0] wd;
        logic [63:0] e_pc, e_ipc;
        logic [31:0] e_ins;
        logic        e_v;
    } vec_t;

    localparam int NV = 27;
    vec_t tv [NV];

    function automatic logic [31:0] w(input int i);
        case (i)
            0: return 32'h00100093;
            1: return 32'h00200113;
            2: return 32'h00300193;
            3: return 32'h00400213;
            default: return 32'hA0000000 | 32'(i);
        endcase
    endfunction

    function automatic vec_t mk(input logic rst, stl, br, input logic [63:0] tgt, input logic we,
                                input logic [5:0] wa, input logic [31:0] wd, input logic [63:0] e_pc,
                                input logic [63:0] e_ipc, input logic [31:0] e_ins, input logic e_v);
        return '{rst, stl, br, tgt, we, wa, wd, e_pc, e_ipc, e_ins, e_v};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [63:0] e_pc, e_ipc, input logic [31:0] e_ins,
                           input logic e_v);
        chk({tag, " PC_Out"}, PC_Out, e_pc);
        chk({tag, " ifid_pc"}, ifid_pc, e_ipc);
        chk({tag, " ifid_instr"}, 64'(ifid_instr), 64'(e_ins));
        chk({tag, " ifid_valid"}, 64'(ifid_valid), 64'(e_v));
`ifdef IF_STAGE_PERF_CNT_EN
        chk({tag, " fetch_cnt"}, 64'(fetch_cnt), 64'(m_fetch));
        chk({tag, " stall_cnt"}, 64'(stall_cnt), 64'(m_stall));
        chk({tag, " flush_cnt"}, 64'(flush_cnt), 64'(m_flush));
`endif
    endtask

    initial begin
        tv[0]  = mk(0,0,0,0,0,0,0, 64'h4,   64'h0,   w(0), 1);
        tv[1]  = mk(0,0,0,0,0,0,0, 64'h8,   64'h4,   w(1), 1);
        tv[2]  = mk(0,1,0,0,0,0,0, 64'h8,   64'h4,   w(1), 1);
        tv[3]  = mk(0,1,0,0,0,0,0, 64'h8,   64'h4,   w(1), 1);
        tv[4]  = mk(0,1,0,0,0,0,0, 64'h8,   64'h4,   w(1), 1);
        tv[5]  = mk(0,0,0,0,0,0,0, 64'hC,   64'h8,   w(2), 1);
        tv[6]  = mk(0,0,1,64'h10,0,0,0, 64'h10, 64'h0, NOP, 0);
        tv[7]  = mk(0,0,0,0,0,0,0, 64'h14,  64'h10,  w(4), 1);
        tv[8]  = mk(0,1,1,64'h6,0,0,0, 64'h4, 64'h0, NOP, 0);
        tv[9]  = mk(0,0,0,0,0,0,0, 64'h8,   64'h4,   w(1), 1);
        tv[10] = mk(0,0,1,64'hFFFF_FFFF_FFFF_FFFC,0,0,0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, NOP, 0);
        tv[11] = mk(0,0,0,0,0,0,0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, w(63), 1);
        tv[12] = mk(0,0,0,0,0,0,0, 64'h4,   64'h0,   w(0), 1);
        tv[13] = mk(0,0,1,64'hF8,0,0,0, 64'hF8, 64'h0, NOP, 0);
        tv[14] = mk(0,0,0,0,0,0,0, 64'hFC,  64'hF8,  w(62), 1);
        tv[15] = mk(0,0,0,0,0,0,0, 64'h100, 64'hFC,  w(63), 1);
        tv[16] = mk(0,0,0,0,0,0,0, 64'h104, 64'h100, w(0), 1);
        tv[17] = mk(0,0,0,0,0,0,0, 64'h108, 64'h104, w(1), 1);
        tv[18] = mk(0,0,0,0,0,0,0, 64'h10C, 64'h108, w(2), 1);
        tv[19] = mk(0,0,0,0,0,0,0, 64'h110, 64'h10C, w(3), 1);
        tv[20] = mk(0,0,0,0,0,0,0, 64'h114, 64'h110, w(4), 1);
        tv[21] = mk(0,0,0,0,1,6'd5,NEW5, 64'h118, 64'h114, w(5), 1);
        tv[22] = mk(0,0,1,64'h14,0,0,0, 64'h14, 64'h0, NOP, 0);
        tv[23] = mk(0,0,0,0,0,0,0, 64'h18,  64'h14,  NEW5, 1);
        tv[24] = mk(0,0,0,0,0,0,0, 64'h1C,  64'h18,  w(6), 1);
        tv[25] = mk(1,1,1,64'h40,0,0,0, 64'h0, 64'h0, NOP, 0);
        tv[26] = mk(0,0,0,0,0,0,0, 64'h4,   64'h0,   w(0), 1);

        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
        for (int i = 0; i < 64; i++) begin
            imem_we = 1'b1; imem_waddr = 6'(i); imem_wdata = w(i);
            @(posedge clk); #1;
        end
        imem_we = 1'b0;
        chk_all("reset", 64'h0, 64'h0, NOP, 1'b0);

        for (int k = 0; k < NV; k++) begin
            reset = tv[k].rst; stall = tv[k].stl; branch_taken = tv[k].br;
            branch_target = tv[k].tgt; imem_we = tv[k].we; imem_waddr = tv[k].wa; imem_wdata = tv[k].wd;
            @(posedge clk); #1;
            if (tv[k].rst) begin
                m_fetch = 0; m_stall = 0; m_flush = 0;
            end else if (tv[k].br) m_flush++;
            else if (tv[k].stl) m_stall++;
            else m_fetch++;
            chk_all($sformatf("vec%0d", k), tv[k].e_pc, tv[k].e_ipc, tv[k].e_ins, tv[k].e_v);
        end

        reset = 1'b0; branch_taken = 1'b0; imem_we = 1'b0; stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            m_stall++;
            chk_all($sformatf("hold%0d", i), 64'h4, 64'h0, w(0), 1'b1);
        end
        stall = 1'b0;
        @(posedge clk); #1;
        m_fetch++;
        chk_all("resume", 64'h8, 64'h4, w(1), 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage for the pipelined RISC-V core. Holds the program counter, reads a word-addressed instruction memory, and drives the IF/ID pipeline register consumed by the decode stage. Accepts a load-use stall from the hazard logic and a taken-branch redirect from EX. The redirect flushes the fetched slot with a NOP bubble.

## Interface
- PC_RESET, 64'h0: PC value loaded on reset.
- IMEM_WORDS, 64: instruction memory depth in 32-bit words (power of two, ≥2).
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- stall  input  1  hold PC and IF/ID (load-use hazard)
- branch_taken  input  1  redirect PC to branch_target, bubble IF/ID
- branch_target  input  64  redirect address from EX
- imem_we  input  1  instruction memory preload write enable
- imem_waddr  input  $clog2(IMEM_WORDS)  preload word index
- imem_wdata  input  32  preload word
- PC_Out  output  64  current fetch PC (registered)
- ifid_pc  output  64  PC of instruction in IF/ID
- ifid_instr  output  32  instruction in IF/ID
- ifid_valid  output  1  IF/ID holds a real instruction
- fetch_cnt, stall_cnt, flush_cnt  output  32 each  (only with IF_STAGE_PERF_CNT_EN)

## Operation
- Fetch index = PC_Out[2 +: $clog2(IMEM_WORDS)]. Addresses beyond depth wrap modulo IMEM_WORDS. PC_Out[1:0] is ignored for fetch.
- Priority per clock edge (reset > branch_taken > stall > normal):
  - reset: PC_Out←PC_RESET, ifid_pc←0, ifid_instr←NOP (32'h00000013), ifid_valid←0, counters←0. Memory contents unaffected.
  - branch_taken: PC_Out←{branch_target[63:2],2'b00}, ifid_pc←0, ifid_instr←NOP, ifid_valid←0, flush_cnt+1. Overrides a simultaneous stall.
  - stall: PC_Out, ifid_* hold, stall_cnt+1.
  - normal: PC_Out←PC_Out+4 (64-bit wrap), ifid_pc←PC_Out, ifid_instr←imem[index], ifid_valid←1, fetch_cnt+1.
- Memory read is combinational. Write is on the clock edge. A fetch and a write to the same word on the same edge capture the old word.
- Preload writes are accepted in every state, including during reset.
- Reset mid-stream discards the in-flight IF/ID contents with no further effect.

## Timing
- Fetch latency 1 cycle: the word at PC_Out appears on ifid_instr after the next edge.
- The first valid IF/ID occurs one edge after reset deasserts: ifid_pc=PC_RESET.
- Branch penalty: one bubble from this stage. The target instruction reaches IF/ID two edges after the branch_taken edge.
- Stall: while stall=1 and branch_taken=0, the outputs are frozen. Fetch resumes on the first edge with stall=0.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- IF_STAGE_PERF_CNT_EN defined: the three 32-bit counters and ports exist.
  - They reset to 0 and wrap at 2^32.
  - Each increments on the edge where its condition (normal fetch / stall / branch flush) wins the priority.
- IF_STAGE_PERF_CNT_EN undefined: the counters and ports are absent, and there is no other behavioural difference.

## Structure
- Shared package riscv_pkg holds:
  - XLEN=64 and ILEN=32
  - NOP_INSTR=32'h00000013
  - the instruction_t typedef
- Sub-module instruction_memory (parameter IMEM_WORDS) has one combinational read port and one synchronous write port, with no reset. if_stage instantiates it once.
- The PC register and the IF/ID register live in if_stage.

## Test plan
- Preload words 0..3 = 0x00100093, 0x00200113, 0x00300193, 0x00400213. Release reset at PC_RESET=0. Over 4 edges, ifid_pc steps 0,4,8,12, ifid_instr matches, and valid=1.
- Raise stall for 3 cycles at PC_Out=8: PC_Out stays 8, IF/ID holds pc 4 / 0x00200113, stall_cnt=3, then resume.
- branch_taken with target 0x10 while PC_Out=0xC: next edge gives PC_Out=0x10, ifid_instr=NOP, valid=0. The following edge gives ifid_pc=0x10.
- branch_taken and stall together with target 0x6: redirect wins, PC_Out=0x4, stall_cnt unchanged, flush_cnt+1.
- Run PC to (IMEM_WORDS*4) with IMEM_WORDS=64, i.e. PC 0x100: the fetch returns word 0. Writing word 5 on the same edge it is fetched captures the old value, and the next fetch of word 5 sees the new value.
- Assert reset mid-run: PC_Out=PC_RESET, valid=0, counters 0 on the next edge. Memory preload is retained.
